ppwm_sched: RTL

PPWM_SCHED -- requirements
Module: ppwm_sched

---
 rtl/ppwm_pkg.sv | 16 +
 rtl/ppwm_sched_if.sv | 27 ++
 rtl/ppwm_prescaler.sv | 38 +++
 rtl/ppwm_sched.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ppwm_pkg.sv
// Shared types and default widths for the programmable PWM scheduler.
// Holds the scheduler state encoding and the default parameter values.
package ppwm_pkg;

  localparam int CNT_W_DEF   = 8;
  localparam int INSTR_W_DEF = 7;
  localparam int PC_W_DEF    = 4;
  localparam int PRE_W_DEF   = 4;

  typedef enum logic [1:0] {
    HALT,
    RUN,
    DRAIN
  } sched_state_e;

endpackage

// File: rtl/ppwm_sched_if.sv
// Program-write handshake bundle: valid/ready plus address and data.
// master drives valid/addr/data, slave answers with ready.
interface ppwm_sched_if #(
  parameter int PC_WIDTH    = 4,
  parameter int INSTR_WIDTH = 7
);

  logic                   prog_valid_i;
  logic                   prog_ready_o;
  logic [PC_WIDTH-1:0]    prog_addr_i;
  logic [INSTR_WIDTH-1:0] prog_data_i;

  modport master (
    output prog_valid_i,
    output prog_addr_i,
    output prog_data_i,
    input  prog_ready_o
  );

  modport slave (
    input  prog_valid_i,
    input  prog_addr_i,
    input  prog_data_i,
    output prog_ready_o
  );

endinterface

// File: rtl/ppwm_prescaler.sv
// Prescaler: counts 0..P and ticks when it reaches P.
// Ports: clk, rst, clear_i (held while halted), load_i (period start), prescale_i, tick_o.
module ppwm_prescaler #(
  parameter int PRESCALE_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_i,
  input  logic                      load_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      tick_o
);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] p_q, p_d;

  assign tick_o = !clear_i && (cnt_q == p_q);

  // P only changes while halted or at a period start,
  // so a period never sees a mid-flight reload.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    p_d   = p_q;
    if (clear_i || load_i || tick_o) cnt_d = '0;
    if (clear_i || load_i) p_d = prescale_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      p_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      p_q   <= p_d;
    end
  end

endmodule

// File: rtl/ppwm_sched.sv
// PWM period scheduler: HALT/RUN/DRAIN FSM, prescaled period counter, program memory.
// Ports: clk, rst, en_i, prescale_i, prog (write handshake), pc_i, instr_o,
// start_o, global_counter_o, running_o. Macro PPWM_SHADOW_PROG_EN adds a shadow bank.
import ppwm_pkg::*;

module ppwm_sched #(
  parameter int COUNTER_WIDTH  = CNT_W_DEF,
  parameter int INSTR_WIDTH    = INSTR_W_DEF,
  parameter int PC_WIDTH       = PC_W_DEF,
  parameter int PRESCALE_WIDTH = PRE_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  ppwm_sched_if.slave               prog,
  input  logic [PC_WIDTH-1:0]       pc_i,
  output logic [INSTR_WIDTH-1:0]    instr_o,
  output logic                      start_o,
  output logic [COUNTER_WIDTH-1:0]  global_counter_o,
  output logic                      running_o
);

  localparam int DEPTH = 2 ** PC_WIDTH;

  typedef logic [INSTR_WIDTH-1:0] word_t;

  sched_state_e             state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     start_q, start_d;
  logic                     halt, tick, wrap, wr;

  word_t act_q [DEPTH];
  word_t act_d [DEPTH];

  assign halt = (state_q == HALT);
  assign wrap = tick && (&cnt_q);

  ppwm_prescaler #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_presc (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (halt),
    .load_i     (start_d),
    .prescale_i (prescale_i),
    .tick_o     (tick)
  );

  // RUN and DRAIN only differ in what happens at the wrap,
  // decided by en_i at that edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    unique case (state_q)
      HALT: begin
        cnt_d = '0;
        if (en_i) begin
          state_d = RUN;
          start_d = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (tick) cnt_d = cnt_q + 1'b1;
        if (wrap && !en_i) begin
          state_d = HALT;
        end else begin
          state_d = en_i ? RUN : DRAIN;
          start_d = wrap;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HALT;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

`ifdef PPWM_SHADOW_PROG_EN
  word_t sh_q [DEPTH];
  word_t sh_d [DEPTH];
  logic  dirty_q, dirty_d;

  assign prog.prog_ready_o = 1'b1;
  assign wr = prog.prog_valid_i;

  // Copy first, then apply a same-edge write so it stays pending.
  always_comb begin
    act_d   = act_q;
    sh_d    = sh_q;
    dirty_d = dirty_q;
    if (start_d && dirty_q) begin
      act_d   = sh_q;
      dirty_d = 1'b0;
    end
    if (wr) begin
      sh_d[prog.prog_addr_i] = prog.prog_data_i;
      if (halt) act_d[prog.prog_addr_i] = prog.prog_data_i;
      else      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q   <= '{default: '0};
      sh_q    <= '{default: '0};
      dirty_q <= 1'b0;
    end else begin
      act_q   <= act_d;
      sh_q    <= sh_d;
      dirty_q <= dirty_d;
    end
  end
`else
  assign prog.prog_ready_o = halt;
  assign wr = prog.prog_valid_i && halt;

  always_comb begin
    act_d = act_q;
    if (wr) act_d[prog.prog_addr_i] = prog.prog_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) act_q <= '{default: '0};
    else     act_q <= act_d;
  end
`endif

  assign instr_o          = act_q[pc_i];
  assign start_o          = start_q;
  assign global_counter_o = cnt_q;
  assign running_o        = !halt;

endmodule
